// File: rtl/tetris_vga_renderer.sv
// VGA scan-out of the 10x20 tetris board: 640x480@60 timing from a 50 MHz clock,
// with the board snapshotted at the start of vertical blanking so frames never tear.
module tetris_vga_renderer #(
  parameter int          CELL       = 20,
  parameter int          X0         = 220,
  parameter int          Y0         = 40,
  parameter logic [23:0] FILL_RGB   = 24'hFFD000,
  parameter logic [23:0] BORDER_RGB = 24'hFFFFFF,
  parameter int          H_VIS      = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VIS      = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [199:0] board,
  output logic         frame_start,
  output logic         vga_HS,
  output logic         vga_VS,
  output logic         vga_blank_n,
  output logic         vga_clk,
  output logic [7:0]   R,
  output logic [7:0]   G,
  output logic [7:0]   B
);

  localparam int SW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] BX_BEG  = 10'(X0);
  localparam logic [9:0] BX_END  = 10'(X0 + 10 * CELL);
  localparam logic [9:0] BY_BEG  = 10'(Y0);
  localparam logic [9:0] BY_END  = 10'(Y0 + 20 * CELL);
  localparam logic [9:0] RX_BEG  = 10'(X0 - 2);
  localparam logic [9:0] RX_END  = 10'(X0 + 10 * CELL + 2);
  localparam logic [9:0] RY_BEG  = 10'(Y0 - 2);
  localparam logic [9:0] RY_END  = 10'(Y0 + 20 * CELL + 2);
  localparam logic [9:0] X_LOAD  = 10'(X0 - 1);
  localparam logic [9:0] Y_LOAD  = 10'(Y0 - 1);

  logic          pix_en;
  logic [9:0]    h, v;
  logic [SW-1:0] sub_x, sub_y;
  logic [3:0]    col;
  logic [4:0]    row;
  logic [199:0]  board_q;

  logic          in_bx, in_by, in_rx, in_ry, visible, hs_n, vs_n, cell_on;
  logic [7:0]    cell_idx;
  logic [23:0]   pix_rgb;

  assign vga_clk = pix_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pix_en <= 1'b0;
    else         pix_en <= ~pix_en;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Cell counters are (re)loaded one pixel before the board edge so they
  // already hold cell 0 when h/v first enter the board area.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sub_x <= '0;
      col   <= '0;
      sub_y <= '0;
      row   <= '0;
    end else if (pix_en) begin
      if (h == X_LOAD) begin
        sub_x <= '0;
        col   <= '0;
      end else if (in_bx) begin
        if (sub_x == SUB_LAST) begin
          sub_x <= '0;
          col   <= col + 4'd1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
      if (h == H_LAST) begin
        if (v == Y_LOAD) begin
          sub_y <= '0;
          row   <= '0;
        end else if (in_by) begin
          if (sub_y == SUB_LAST) begin
            sub_y <= '0;
            row   <= row + 5'd1;
          end else begin
            sub_y <= sub_y + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    in_bx    = (h >= BX_BEG) && (h < BX_END);
    in_by    = (v >= BY_BEG) && (v < BY_END);
    in_rx    = (h >= RX_BEG) && (h < RX_END);
    in_ry    = (v >= RY_BEG) && (v < RY_END);
    visible  = (h < H_VIS_C) && (v < V_VIS_C);
    hs_n     = !((h >= HS_BEG) && (h < HS_END));
    vs_n     = !((v >= VS_BEG) && (v < VS_END));
    cell_idx = {3'b000, row} * 8'd10 + {4'b0000, col};
    cell_on  = board_q[cell_idx];
    pix_rgb  = 24'h000000;
    if (visible) begin
      if (in_bx && in_by) pix_rgb = cell_on ? FILL_RGB : 24'h000000;
      else if (in_rx && in_ry) pix_rgb = BORDER_RGB;
    end
  end

  // frame_start is raised one clk ahead so it is high during the clk whose
  // closing edge captures board into board_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_start <= 1'b0;
      vga_HS      <= 1'b1;
      vga_VS      <= 1'b1;
      vga_blank_n <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      board_q     <= '0;
    end else begin
      frame_start <= !pix_en && (h == '0) && (v == V_VIS_C);
      if (pix_en) begin
        vga_HS      <= hs_n;
        vga_VS      <= vs_n;
        vga_blank_n <= visible;
        {R, G, B}   <= pix_rgb;
        if ((h == '0) && (v == V_VIS_C)) board_q <= board;
      end
    end
  end

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Bench for tetris_vga_renderer: a scaled-timing instance checked every clk against
// a pixel model, plus a full 640x480 instance pinned on its first lines.
module tb_tetris_vga_renderer;

  localparam int C = 2, X0 = 10, Y0 = 4;
  localparam int HV = 48, HF = 4, HSY = 8, HB = 4;
  localparam int VV = 50, VF = 3, VSY = 2, VB = 5;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FP = HT * VT;
  localparam logic [23:0] FILL = 24'hFFD000;
  localparam logic [23:0] BORD = 24'hFFFFFF;

  logic         clk, resetn;
  logic [199:0] board;
  logic         s_fs, s_hs, s_vs, s_bl, s_vclk;
  logic [7:0]   s_r, s_g, s_b;
  logic         f_fs, f_hs, f_vs, f_bl, f_vclk;
  logic [7:0]   f_r, f_g, f_b;

  int checks = 0;
  int failures = 0;
  int t;
  logic [199:0] mb;
  bit run0 = 1'b1;

  tetris_vga_renderer #(
    .CELL(C), .X0(X0), .Y0(Y0),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk), .resetn(resetn), .board(board), .frame_start(s_fs),
    .vga_HS(s_hs), .vga_VS(s_vs), .vga_blank_n(s_bl), .vga_clk(s_vclk),
    .R(s_r), .G(s_g), .B(s_b)
  );

  tetris_vga_renderer dut_full (
    .clk(clk), .resetn(resetn), .board(board), .frame_start(f_fs),
    .vga_HS(f_hs), .vga_VS(f_vs), .vga_blank_n(f_bl), .vga_clk(f_vclk),
    .R(f_r), .G(f_g), .B(f_b)
  );

  // clock / reset-relative clk counter and model snapshot
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t  <= 0;
      mb <= '0;
    end else begin
      t <= t + 1;
      if (((t + 1) % 2 == 0) && (((t + 1) / 2 - 1) % FP) == VV * HT) mb <= board;
    end
  end

  // Expected {HS,VS,blank_n,RGB,frame_start,vga_clk} after clk edge n since release.
  function automatic logic [28:0] model(input int n, input logic [199:0] brd);
    int p, h, v;
    logic hs, vs, bl, fs, vc;
    logic [23:0] c;
    vc = (n % 2 == 1);
    fs = (n % 2 == 1) && ((((n - 1) / 2) % FP) == VV * HT);
    hs = 1'b1; vs = 1'b1; bl = 1'b0; c = 24'h0;
    if (n >= 2) begin
      p  = n / 2 - 1;
      h  = p % HT;
      v  = (p / HT) % VT;
      bl = (h < HV) && (v < VV);
      hs = !((h >= HV + HF) && (h < HV + HF + HSY));
      vs = !((v >= VV + VF) && (v < VV + VF + VSY));
      if (bl) begin
        if (h >= X0 && h < X0 + 10 * C && v >= Y0 && v < Y0 + 20 * C) begin
          if (brd[((v - Y0) / C) * 10 + (h - X0) / C]) c = FILL;
        end else if (h >= X0 - 2 && h < X0 + 10 * C + 2 && v >= Y0 - 2 && v < Y0 + 20 * C + 2) begin
          c = BORD;
        end
      end
    end
    return {hs, vs, bl, c, fs, vc};
  endfunction

  // per-clk scoreboard against the model
  always @(negedge clk) begin
    logic [28:0] exp_v, act_v;
    exp_v = model(t, mb);
    act_v = {s_hs, s_vs, s_bl, s_r, s_g, s_b, s_fs, s_vclk};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL pixel t=%0d actual=%h required=%h", t, act_v, exp_v);
    end
  end

  // edge timestamps for the literal timing checks
  int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1;
  int vs_fall1 = -1, vs_fall2 = -1, vs_rise1 = -1;
  int fs_first = -1, blank_cnt = 0;
  int fh_fall1 = -1, fh_fall2 = -1, fh_rise1 = -1, f_blank_cnt = 0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_fhs = 1'b1;

  always @(negedge clk) begin
    if (run0 && resetn) begin
      if (p_hs && !s_hs) begin
        if (hs_fall1 < 0) hs_fall1 = t; else if (hs_fall2 < 0) hs_fall2 = t;
      end
      if (!p_hs && s_hs && hs_rise1 < 0) hs_rise1 = t;
      if (p_vs && !s_vs) begin
        if (vs_fall1 < 0) vs_fall1 = t; else if (vs_fall2 < 0) vs_fall2 = t;
      end
      if (!p_vs && s_vs && vs_rise1 < 0) vs_rise1 = t;
      if (s_fs && fs_first < 0) fs_first = t;
      if (s_bl && t <= 2 * FP) blank_cnt++;
      if (p_fhs && !f_hs) begin
        if (fh_fall1 < 0) fh_fall1 = t; else if (fh_fall2 < 0) fh_fall2 = t;
      end
      if (!p_fhs && f_hs && fh_rise1 < 0) fh_rise1 = t;
      if (f_bl && t <= 1600) f_blank_cnt++;
      p_hs = s_hs; p_vs = s_vs; p_fhs = f_hs;
    end
  end

  // driver / checker tasks
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_rst(input string name, input logic [27:0] act);
    checks++;
    if (act !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, {1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
    end
  endtask

  task automatic wait_px(input int f, input int x, input int y, output bit found);
    found = 1'b0;
    for (int n = 0; n < 40000 && !found; n++) begin
      @(negedge clk);
      if (t >= 2 && t % 2 == 0 && (t / 2 - 1) / FP == f &&
          (t / 2 - 1) % HT == x && ((t / 2 - 1) / HT) % VT == y) found = 1'b1;
    end
  endtask

  task automatic check_px(input int f, input int x, input int y, input logic [23:0] req, input string name);
    bit found;
    wait_px(f, x, y, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s actual=timeout required=%h", name, req);
    end else if ({s_r, s_g, s_b} !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, {s_r, s_g, s_b}, req);
    end
  endtask

  task automatic goto_px(input int f, input int x, input int y, input string name);
    bit found;
    wait_px(f, x, y, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s actual=timeout required=reached", name);
    end
  endtask

  initial begin
    resetn = 1'b0;
    board  = '1;
    repeat (4) @(negedge clk);
    chk_rst("reset_small", {s_hs, s_vs, s_bl, s_r, s_g, s_b, s_fs});
    chk_rst("reset_full", {f_hs, f_vs, f_bl, f_r, f_g, f_b, f_fs});
    #2;
    resetn = 1'b1;
    board  = '0;
    board[0] = 1'b1;

    // frame 0: board_q cleared by reset, border ring
    check_px(0, 8, 2, BORD, "border_tl");
    check_px(0, 10, 4, 24'h0, "board_q_reset_clear");
    check_px(0, 7, 20, 24'h0, "outside_left");
    check_px(0, 9, 20, BORD, "border_left");
    check_px(0, 10, 20, 24'h0, "empty_cell");
    check_px(0, 31, 45, BORD, "border_br");

    // frame 1: only bit 0
    check_px(1, 10, 4, FILL, "bit0_tl");
    check_px(1, 12, 4, 24'h0, "bit0_right_edge");
    check_px(1, 11, 5, FILL, "bit0_br");
    check_px(1, 10, 6, 24'h0, "bit0_bottom_edge");
    goto_px(1, 0, 30, "goto_f1");
    #2;
    board = '0;
    board[199] = 1'b1;

    // frame 2: only bit 199
    check_px(2, 27, 42, 24'h0, "bit199_left_edge");
    check_px(2, 28, 42, FILL, "bit199_tl");
    check_px(2, 29, 43, FILL, "bit199_br");
    check_px(2, 28, 44, BORD, "bit199_below_border");
    goto_px(2, 0, 45, "goto_f2");
    #2;
    board = '0;

    // frame 3: board changes mid-frame, display must not tear
    goto_px(3, 0, 20, "goto_f3");
    #2;
    board = '1;
    check_px(3, 20, 30, 24'h0, "no_tear_mid");
    check_px(3, 29, 43, 24'h0, "no_tear_last");
    check_px(4, 10, 4, FILL, "next_frame_first");
    check_px(4, 20, 30, FILL, "next_frame_mid");

    // mid-frame reset
    goto_px(4, 25, 30, "goto_f4");
    #2;
    run0   = 1'b0;
    resetn = 1'b0;
    #1;
    chk_rst("reset_mid_frame", {s_hs, s_vs, s_bl, s_r, s_g, s_b, s_fs});
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b1;
    check_px(0, 20, 30, 24'h0, "mid_reset_board_q_clear");
    check_px(1, 20, 30, FILL, "after_reset_snapshot");

    chk("hs_first_fall", hs_fall1, 2 * (HV + HF) + 2);
    chk("hs_period", hs_fall2 - hs_fall1, 128);
    chk("hs_low_width", hs_rise1 - hs_fall1, 16);
    chk("vs_first_fall", vs_fall1, 6786);
    chk("vs_period", vs_fall2 - vs_fall1, 7680);
    chk("vs_low_width", vs_rise1 - vs_fall1, 256);
    chk("frame_start_first", fs_first, 6401);
    chk("blank_clks_frame", blank_cnt, 4800);
    chk("full_hs_first_fall", fh_fall1, 2 * 656 + 2);
    chk("full_hs_period", fh_fall2 - fh_fall1, 1600);
    chk("full_hs_low_width", fh_rise1 - fh_fall1, 192);
    chk("full_blank_line0_px", f_blank_cnt / 2, 640);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
